// File: rtl/checksum_frame_if.sv
// Sample-stream and result bus of the frame checksum engine.
// The host side drives start/mode/dv/data; the engine drives the results and status.
interface checksum_frame_if #(
  parameter int DATA_W = 8,
  parameter int SUM_W  = 24,
  parameter int CNT_W  = 16
) ();
  logic              start;
  logic [1:0]        mode;
  logic              dv;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              done;
  logic              done_pulse;
  logic [CNT_W-1:0]  count;
  logic [7:0]        status;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_b;

  modport master (
    output start, mode, dv, data,
    input  busy, done, done_pulse, count, status, sum, sum_b
  );

  modport slave (
    input  start, mode, dv, data,
    output busy, done, done_pulse, count, status, sum, sum_b
  );
endinterface

// File: rtl/checksum_frame.sv
// Frame checksum engine: accumulates FRAME_LEN samples with wrap-sum, XOR,
// Fletcher dual sum or one's-complement sum, and holds the result until re-armed.
module checksum_frame #(
  parameter int DATA_W    = 8,
  parameter int SUM_W     = 24,
  parameter int CNT_W     = 16,
  parameter int FRAME_LEN = 256
) (
  input  logic             clk,
  input  logic             rstx,
  checksum_frame_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [1:0]         mode_reg, mode_next;
  logic [SUM_W-1:0]   sum_reg, sum_next;
  logic [SUM_W-1:0]   sum_b_reg, sum_b_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               pending_reg, pending_next;
  logic               ovf_reg, ovf_next;
  logic               late_reg, late_next;
  logic               pulse_reg, pulse_next;

  logic [DATA_W-1:0]  sample;
  logic [SUM_W-1:0]   data_ext;
  logic [SUM_W:0]     add_a;
  logic [SUM_W:0]     add_b;
  logic               last;

  assign sample   = bus.data;
  assign data_ext = SUM_W'(sample);
  // One extra bit on each adder exposes the carry-out for overflow / end-around carry.
  assign add_a    = {1'b0, sum_reg} + {1'b0, data_ext};
  assign add_b    = {1'b0, sum_b_reg} + {1'b0, add_a[SUM_W-1:0]};
  // Compare against FRAME_LEN-1 so FRAME_LEN = 2^CNT_W works with a CNT_W counter.
  assign last     = (count_reg == CNT_W'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mode_next    = mode_reg;
    sum_next     = sum_reg;
    sum_b_next   = sum_b_reg;
    count_next   = count_reg;
    pending_next = pending_reg;
    ovf_next     = ovf_reg;
    late_next    = late_reg;
    pulse_next   = 1'b0;

    // start wins over dv in every state: the coinciding sample is dropped.
    if (bus.start) begin
      state_next = RUN;
      mode_next  = bus.mode;
      sum_next   = '0;
      sum_b_next = '0;
      count_next = '0;
      ovf_next   = 1'b0;
      late_next  = 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (bus.dv) begin
            case (mode_reg)
              2'd0: begin
                sum_next = add_a[SUM_W-1:0];
                ovf_next = ovf_reg | add_a[SUM_W];
              end
              2'd1: begin
                sum_next = sum_reg ^ data_ext;
              end
              2'd2: begin
                sum_next   = add_a[SUM_W-1:0];
                sum_b_next = add_b[SUM_W-1:0];
                ovf_next   = ovf_reg | add_a[SUM_W] | add_b[SUM_W];
              end
              default: begin
                sum_next = add_a[SUM_W-1:0] + SUM_W'(add_a[SUM_W]);
              end
            endcase
            count_next = count_reg + CNT_W'(1);
            if (last) begin
              state_next   = DONE;
              pulse_next   = 1'b1;
              pending_next = 1'b0;
            end
          end
        end
        DONE: begin
          if (bus.dv) begin
            late_next = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      mode_reg    <= 2'd0;
      sum_reg     <= '0;
      sum_b_reg   <= '0;
      count_reg   <= '0;
      pending_reg <= 1'b1;
      ovf_reg     <= 1'b0;
      late_reg    <= 1'b0;
      pulse_reg   <= 1'b0;
    end else begin
      mode_reg    <= mode_next;
      sum_reg     <= sum_next;
      sum_b_reg   <= sum_b_next;
      count_reg   <= count_next;
      pending_reg <= pending_next;
      ovf_reg     <= ovf_next;
      late_reg    <= late_next;
      pulse_reg   <= pulse_next;
    end
  end

  assign bus.busy       = (state_reg == RUN);
  assign bus.done       = (state_reg == DONE);
  assign bus.done_pulse = pulse_reg;
  assign bus.count      = count_reg;
  assign bus.sum        = sum_reg;
  assign bus.sum_b      = sum_b_reg;
  assign bus.status     = {3'b000, late_reg, ovf_reg, (state_reg == DONE),
                           (state_reg == RUN), pending_reg};

endmodule
